// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: decode-side control, instruction-memory port and decode outputs.
// master = fetch_unit, slave = the surrounding pipeline / memory.
interface fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        halt;
    logic        imemRd;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        imemDone;
    logic        imemErr;
    logic [15:0] instr;
    logic [15:0] PC;
    logic        valid;
    logic        err;

    modport master (
        input  stall, redirect, redirectPC, halt,
        input  imemData, imemDone, imemErr,
        output imemRd, imemAddr,
        output instr, PC, valid, err
    );

    modport slave (
        output stall, redirect, redirectPC, halt,
        output imemData, imemDone, imemErr,
        input  imemRd, imemAddr,
        input  instr, PC, valid, err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, HOLD buffer, NOP injection.
// Optional FETCH_HALT_DETECT_EN: a delivered opcode-0 word stops issue until rst/redirect.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        SQUASH
    } state_t;

    localparam logic [15:0] NOP = 16'h0800;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc_out_q;
    logic        valid_q;
    logic [15:0] buf_instr_q;
    logic [15:0] buf_pc_q;
    logic        err_q;

    logic        dlv_mem;
    logic        dlv_buf;
    logic        halt_eff;
    logic        issue;

`ifdef FETCH_HALT_DETECT_EN
    logic        halt_seen_q;
    logic [15:0] dlv_instr;
    logic        dlv_halt;
`endif

    // Delivery and issue decisions for the current cycle.
    always_comb begin
        dlv_mem = (state_q == WAIT) && bus.imemDone && !bus.stall;
        dlv_buf = (state_q == HOLD) && !bus.stall;
`ifdef FETCH_HALT_DETECT_EN
        dlv_instr = (state_q == HOLD) ? buf_instr_q : bus.imemData;
        dlv_halt  = (dlv_mem || dlv_buf) && (dlv_instr[15:11] == 5'b00000);
        halt_eff  = bus.halt || halt_seen_q || dlv_halt;
`else
        halt_eff  = bus.halt;
`endif
        issue = !rst && !halt_eff && !bus.redirect &&
                ((state_q == IDLE) ||
                 ((state_q == WAIT) && bus.imemDone && !bus.stall) ||
                 dlv_buf);
    end

    assign bus.imemRd   = issue;
    assign bus.imemAddr = pc_q;
    assign bus.instr    = instr_q;
    assign bus.PC       = pc_out_q;
    assign bus.valid    = valid_q;
    assign bus.err      = err_q;

    // Fetch FSM, PC, output register, HOLD buffer and sticky error.
    // While in WAIT, pc_q already equals the outstanding fetch address + 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= NOP;
            pc_out_q    <= 16'h0000;
            valid_q     <= 1'b0;
            buf_instr_q <= NOP;
            buf_pc_q    <= 16'h0000;
            err_q       <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            halt_seen_q <= 1'b0;
`endif
        end else begin
            if (bus.imemDone &&
                ((state_q == IDLE) || (state_q == HOLD) || bus.imemErr))
                err_q <= 1'b1;

            if (bus.redirect) begin
                pc_q        <= bus.redirectPC;
                instr_q     <= NOP;
                pc_out_q    <= 16'h0000;
                valid_q     <= 1'b0;
                buf_instr_q <= NOP;
                buf_pc_q    <= 16'h0000;
                if (((state_q == WAIT) || (state_q == SQUASH)) && !bus.imemDone)
                    state_q <= SQUASH;
                else
                    state_q <= IDLE;
`ifdef FETCH_HALT_DETECT_EN
                halt_seen_q <= 1'b0;
`endif
            end else begin
                if (issue)
                    pc_q <= pc_q + 16'd2;

                unique case (state_q)
                    IDLE: begin
                        if (!bus.stall) begin
                            instr_q  <= NOP;
                            pc_out_q <= 16'h0000;
                            valid_q  <= 1'b0;
                        end
                        if (issue)
                            state_q <= WAIT;
                    end
                    WAIT: begin
                        if (dlv_mem) begin
                            instr_q  <= bus.imemData;
                            pc_out_q <= pc_q;
                            valid_q  <= 1'b1;
                            state_q  <= issue ? WAIT : IDLE;
                        end else if (bus.imemDone) begin
                            buf_instr_q <= bus.imemData;
                            buf_pc_q    <= pc_q;
                            state_q     <= HOLD;
                        end else if (!bus.stall) begin
                            instr_q  <= NOP;
                            pc_out_q <= 16'h0000;
                            valid_q  <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (dlv_buf) begin
                            instr_q  <= buf_instr_q;
                            pc_out_q <= buf_pc_q;
                            valid_q  <= 1'b1;
                            state_q  <= issue ? WAIT : IDLE;
                        end
                    end
                    SQUASH: begin
                        if (!bus.stall) begin
                            instr_q  <= NOP;
                            pc_out_q <= 16'h0000;
                            valid_q  <= 1'b0;
                        end
                        if (bus.imemDone)
                            state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase

`ifdef FETCH_HALT_DETECT_EN
                if (dlv_halt)
                    halt_seen_q <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and outputs are queued,
// monitors pop and compare whenever imemRd or valid is seen.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_out_q[$];
    logic [15:0] exp_addr_q[$];

    int          lat = 1;
    logic        sp_en = 1'b0;
    logic [15:0] sp_addr = 16'h0000;
    logic [15:0] sp_data = 16'h0000;
    logic        force_done = 1'b0;
    logic        err_inj = 1'b0;

    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic        m_rd_s, m_rst_s, m_fd_s;
    logic [15:0] m_a_s, m_a_p;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.halt = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirectPC = 16'h0000;
        force_done = 1'b0;
        ticks(2);
        #3;
        check("rst_instr", {16'h0, bus.instr}, 32'h0000_0800);
        check("rst_pc", {16'h0, bus.PC}, 32'h0);
        check("rst_valid", {31'h0, bus.valid}, 32'h0);
        check("rst_imemRd", {31'h0, bus.imemRd}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
    endtask

    task automatic release_rst();
        tick();
        rst = 1'b0;
        bus.halt = 1'b0;
    endtask

    task automatic drain(input string name);
        ticks(8);
        check({name, "_out_left"}, exp_out_q.size(), 0);
        check({name, "_addr_left"}, exp_addr_q.size(), 0);
        exp_out_q.delete();
        exp_addr_q.delete();
    endtask

    // Instruction memory model with programmable latency.
    initial begin
        bus.imemDone = 1'b0;
        bus.imemData = 16'h0000;
        bus.imemErr  = 1'b0;
        forever begin
            @(negedge clk);
            m_rd_s  = bus.imemRd;
            m_a_s   = bus.imemAddr;
            m_rst_s = rst;
            m_fd_s  = force_done;
            @(posedge clk);
            #1;
            bus.imemDone = 1'b0;
            bus.imemErr  = 1'b0;
            if (m_rst_s) begin
                m_pend = 1'b0;
            end else begin
                if (m_rd_s) begin
                    m_pend = 1'b1;
                    m_cnt  = lat;
                    m_a_p  = m_a_s;
                end
                if (m_pend) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_pend = 1'b0;
                        bus.imemDone = 1'b1;
                        bus.imemErr  = err_inj;
                        bus.imemData = (sp_en && m_a_p == sp_addr) ?
                                       sp_data : 16'h4000 + m_a_p;
                    end
                end
            end
            if (m_fd_s) bus.imemDone = 1'b1;
        end
    end

    // Monitor: pops expected values on every valid output and every request.
    initial begin
        logic [31:0] e;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.valid) begin
                    if (exp_out_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got %h/%h expected none",
                                 bus.instr, bus.PC);
                    end else begin
                        e = exp_out_q.pop_front();
                        check("out_instr_pc", {bus.instr, bus.PC}, e);
                    end
                end else begin
                    check("nop_when_invalid", {16'h0, bus.instr}, 32'h0000_0800);
                end
                if (bus.imemRd) begin
                    if (exp_addr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_imemRd: got %h expected none",
                                 bus.imemAddr);
                    end else begin
                        a = exp_addr_q.pop_front();
                        check("imemAddr", {16'h0, bus.imemAddr}, {16'h0, a});
                    end
                end
            end
        end
    end

    initial begin
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirectPC = 16'h0000;
        bus.halt = 1'b1;

        // Latency 1: one instruction per cycle.
        lat = 1;
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004};
        exp_out_q  = '{32'h4000_0002, 32'h4002_0004, 32'h4004_0006};
        do_reset();
        release_rst();
        ticks(3);
        bus.halt = 1'b1;
        drain("lat1");

        // Latency 3: valid 1,0,0 pattern, NOPs between.
        lat = 3;
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004};
        exp_out_q  = '{32'h4000_0002, 32'h4002_0004, 32'h4004_0006};
        do_reset();
        release_rst();
        ticks(7);
        bus.halt = 1'b1;
        drain("lat3");

        // Stall while 0xA5A5 returns: HOLD, then release.
        lat = 1;
        sp_en = 1'b1;
        sp_addr = 16'h0000;
        sp_data = 16'hA5A5;
        exp_addr_q = '{16'h0000, 16'h0002};
        exp_out_q  = '{32'hA5A5_0002, 32'h4002_0004};
        do_reset();
        release_rst();
        tick();
        bus.stall = 1'b1;
        #3;
        check("stall_c1_rd", {31'h0, bus.imemRd}, 32'h0);
        tick();
        #3;
        check("stall_c2_rd", {31'h0, bus.imemRd}, 32'h0);
        check("stall_c2_valid", {31'h0, bus.valid}, 32'h0);
        tick();
        bus.stall = 1'b0;
        #3;
        check("release_rd", {31'h0, bus.imemRd}, 32'h1);
        tick();
        bus.halt = 1'b1;
        #3;
        check("release_instr", {15'h0, bus.valid, bus.instr}, 32'h0001_A5A5);
        drain("stall");
        sp_en = 1'b0;

        // Latency 3, redirect one cycle after request: stale word squashed.
        lat = 3;
        exp_addr_q = '{16'h0000, 16'h0040};
        exp_out_q  = '{32'h4040_0042};
        do_reset();
        release_rst();
        tick();
        bus.redirect = 1'b1;
        bus.redirectPC = 16'h0040;
        tick();
        bus.redirect = 1'b0;
        ticks(2);
        #3;
        check("redir_addr", {15'h0, bus.imemRd, bus.imemAddr}, 32'h0001_0040);
        tick();
        bus.halt = 1'b1;
        drain("redirect");

        // HALT opcode at 0x0004, then redirect to 0x0010.
        lat = 1;
        sp_en = 1'b1;
        sp_addr = 16'h0004;
        sp_data = 16'h0000;
`ifdef FETCH_HALT_DETECT_EN
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0010};
        exp_out_q  = '{32'h4000_0002, 32'h4002_0004, 32'h0000_0006,
                       32'h4010_0012};
`else
        exp_addr_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0010};
        exp_out_q  = '{32'h4000_0002, 32'h4002_0004, 32'h0000_0006,
                       32'h4006_0008, 32'h4010_0012};
`endif
        do_reset();
        release_rst();
        ticks(4);
        bus.halt = 1'b1;
        ticks(2);
        bus.halt = 1'b0;
        bus.redirect = 1'b1;
        bus.redirectPC = 16'h0010;
        tick();
        bus.redirect = 1'b0;
        tick();
        bus.halt = 1'b1;
        drain("haltop");
        sp_en = 1'b0;

        // imemDone in IDLE with halt=1: sticky err.
        do_reset();
        tick();
        rst = 1'b0;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        #3;
        check("err_c1", {31'h0, bus.err}, 32'h0);
        tick();
        #3;
        check("err_set", {31'h0, bus.err}, 32'h1);
        ticks(3);
        #3;
        check("err_sticky", {31'h0, bus.err}, 32'h1);
        drain("err_idle");

        // imemErr with a normal response: word still delivered, err set.
        lat = 1;
        err_inj = 1'b1;
        exp_addr_q = '{16'h0000};
        exp_out_q  = '{32'h4000_0002};
        do_reset();
        release_rst();
        tick();
        bus.halt = 1'b1;
        tick();
        #3;
        check("imemErr_err", {31'h0, bus.err}, 32'h1);
        drain("imemErr");
        err_inj = 1'b0;

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
